// File: rtl/avalon_lsu.sv
// Load/store unit: one CPU request becomes one Avalon word transaction with lane placement and load extension.
// Latency: strobes one cycle after accept, response one cycle after the releasing edge; errors respond next cycle.
// Backpressure: req_ready only in IDLE; waitrequest holds the bus phase, optionally bounded by TIMEOUT_CYCLES.
module avalon_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] address,
    output logic        write,
    output logic        read,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUS  = 2'b01,
        RESP = 2'b10
    } state_e;

    localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_CYCLES);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] tmo_q, tmo_d;
    logic [3:0]  be_q, be_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic        err_q, err_d;
    logic        signed_q, signed_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  lane_q, lane_d;

    logic        misaligned;
    logic [31:0] tmo_inc;
    logic [31:0] ld_shift;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        misaligned = (req_size == 2'b11)
                  || (req_size == 2'b01 && req_addr[0])
                  || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    end

    // Lane select uses the latched byte offset; readdata is only consumed on the release edge.
    always_comb begin
        ld_shift = readdata >> {lane_q, 3'b000};
        ld_byte  = ld_shift[7:0];
        ld_half  = lane_q[1] ? readdata[31:16] : readdata[15:0];
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        tmo_d    = tmo_q;
        be_d     = be_q;
        read_d   = read_q;
        write_d  = write_q;
        err_d    = err_q;
        signed_d = signed_q;
        size_d   = size_q;
        lane_d   = lane_q;
        tmo_inc  = tmo_q + 32'd1;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    size_d   = req_size;
                    signed_d = req_signed;
                    lane_d   = req_addr[1:0];
                    rdata_d  = '0;
                    tmo_d    = '0;
                    if (misaligned) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = BUS;
                        addr_d  = {req_addr[31:2], 2'b00};
                        read_d  = !req_write;
                        write_d = req_write;
                        case (req_size)
                            2'b00: begin
                                be_d    = 4'b0001 << req_addr[1:0];
                                wdata_d = {4{req_wdata[7:0]}};
                            end
                            2'b01: begin
                                be_d    = 4'b0011 << req_addr[1:0];
                                wdata_d = {2{req_wdata[15:0]}};
                            end
                            default: begin
                                be_d    = 4'b1111;
                                wdata_d = req_wdata;
                            end
                        endcase
                    end
                end
            end
            BUS: begin
                if (!waitrequest) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    tmo_d   = '0;
                    state_d = RESP;
                    if (read_q) begin
                        case (size_q)
                            2'b00:   rdata_d = {{24{signed_q & ld_byte[7]}}, ld_byte};
                            2'b01:   rdata_d = {{16{signed_q & ld_half[15]}}, ld_half};
                            default: rdata_d = readdata;
                        endcase
                    end
                end else begin
                    tmo_d = tmo_inc;
                    if (TMO_LIMIT != 32'd0 && tmo_inc == TMO_LIMIT) begin
                        read_d  = 1'b0;
                        write_d = 1'b0;
                        tmo_d   = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            tmo_q    <= '0;
            be_q     <= '0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            signed_q <= 1'b0;
            size_q   <= '0;
            lane_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            tmo_q    <= tmo_d;
            be_q     <= be_d;
            read_q   <= read_d;
            write_q  <= write_d;
            err_q    <= err_d;
            signed_q <= signed_d;
            size_q   <= size_d;
            lane_q   <= lane_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_err   = (state_q == RESP) && err_q;
    assign resp_rdata = rdata_q;
    assign address    = addr_q;
    assign read       = read_q;
    assign write      = write_q;
    assign writedata  = wdata_q;
    assign byteenable = be_q;

endmodule

// File: tb/tb_avalon_lsu.sv
// Bench for avalon_lsu: random requests against a byte-level reference model, with a stalling
// Avalon slave that checks bus phases and a response monitor fed from an expectation queue.
module tb_avalon_lsu;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] address, writedata, readdata;
    logic        write, read, waitrequest;
    logic [3:0]  byteenable;

    avalon_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_rdata(resp_rdata), .address(address), .write(write), .read(read),
        .waitrequest(waitrequest), .writedata(writedata), .byteenable(byteenable),
        .readdata(readdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        wr;
        int          waits;
        logic [31:0] rdata;
    } bus_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          due;
    } rsp_t;

    bus_t bus_q[$];
    rsp_t resp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: event missing or unexpected (t=%0t)", name, $time);
    endtask

    // Reference model: access width is 2**size bytes, aligned when addr mod width is 0.
    function automatic logic model_err(input logic [1:0] size, input logic [31:0] a);
        if (size == 2'b11) return 1'b1;
        return (a % (32'd1 << size)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic sgn,
                                               input logic [31:0] a, input logic [31:0] rd);
        int          nb;
        int          k;
        logic [31:0] mask;
        logic [31:0] v;
        nb = 1 << size;
        k  = int'(a % 4);
        if (nb == 4) return rd;
        mask = (32'd1 << (8 * nb)) - 32'd1;
        v    = (rd >> (8 * k)) & mask;
        if (sgn && v[8 * nb - 1]) v = v | ~mask;
        return v;
    endfunction

    task automatic issue(input logic wr, input logic [1:0] size, input logic sgn,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                         input int waits, input bit want_resp);
        bus_t b;
        rsp_t r;
        int   nb;
        int   guard;
        logic err;
        guard = 0;
        @(negedge clk);
        while (!req_ready) begin
            guard++;
            if (guard > 200) begin
                fail_now("req_ready_wait");
                return;
            end
            @(negedge clk);
        end
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = size;
        req_signed = sgn;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_write  = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        err = model_err(size, a);
        if (!err) begin
            nb      = 1 << size;
            b.addr  = a & ~32'd3;
            b.be    = 4'(((1 << nb) - 1) << (a % 4));
            for (int i = 0; i < 4; i++) b.wdata[8*i +: 8] = wd[8*(i % nb) +: 8];
            b.wr    = wr;
            b.waits = waits;
            b.rdata = rd;
            bus_q.push_back(b);
        end
        if (want_resp) begin
            r.err   = err || (waits >= TMO);
            r.rdata = (r.err || wr) ? 32'd0 : model_load(size, sgn, a, rd);
            r.due   = cyc + (err ? 0 : (waits >= TMO ? TMO : waits + 1));
            resp_q.push_back(r);
        end
    endtask

    // Avalon slave: pops the expected bus phase, checks it every cycle it is presented.
    bus_t cur;
    bit   busy = 0;
    bit   ending = 0;
    int   rem = 0;
    int   hi = 0;

    always @(negedge clk) begin
        if (!reset) begin
            busy        = 0;
            ending      = 0;
            waitrequest = 1'b0;
        end else if (ending) begin
            chk("strobe_drop", {31'd0, read | write}, 32'd0);
            ending      = 0;
            busy        = 0;
            waitrequest = 1'b0;
        end else if (busy && !(read || write)) begin
            chk("tmo_stall_cycles", hi, TMO);
            busy        = 0;
            waitrequest = 1'b0;
        end else if (read || write) begin
            if (!busy) begin
                if (bus_q.size() == 0) begin
                    fail_now("unexpected_bus_cycle");
                end else begin
                    cur  = bus_q.pop_front();
                    busy = 1;
                    rem  = cur.waits;
                    hi   = 0;
                end
            end
            if (busy) begin
                chk("rw_exclusive", {31'd0, read & write}, 32'd0);
                chk("address", address, cur.addr);
                chk("byteenable", {28'd0, byteenable}, {28'd0, cur.be});
                chk("write", {31'd0, write}, {31'd0, cur.wr});
                chk("read", {31'd0, read}, {31'd0, !cur.wr});
                if (cur.wr) chk("writedata", writedata, cur.wdata);
                hi++;
                readdata    = cur.rdata;
                waitrequest = (rem != 0);
                if (rem != 0) rem--;
                else ending = 1;
            end
        end else begin
            waitrequest = 1'b0;
            readdata    = $urandom;
        end
    end

    // Response monitor.
    rsp_t e;
    bit   rdy_next = 0;

    always @(negedge clk) begin
        if (!reset) begin
            rdy_next = 0;
        end else begin
            if (rdy_next) begin
                chk("ready_after_resp", {31'd0, req_ready}, 32'd1);
                rdy_next = 0;
            end
            if (resp_valid) begin
                if (resp_q.size() == 0) begin
                    fail_now("unexpected_resp");
                end else begin
                    e = resp_q.pop_front();
                    chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_cycle", cyc, e.due);
                    chk("ready_in_resp", {31'd0, req_ready}, 32'd0);
                    rdy_next = 1;
                end
            end
        end
    end

    initial begin
        int          guard;
        logic        wr;
        logic [1:0]  sz;
        logic [31:0] a;
        int          w;
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        waitrequest = 1'b0;
        readdata   = '0;
        #3;
        chk("rst_read", {31'd0, read}, 32'd0);
        chk("rst_write", {31'd0, write}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_address", address, 32'd0);
        chk("rst_writedata", writedata, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_byteenable", {28'd0, byteenable}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b1;

        // Directed cases.
        issue(1'b1, 2'd0, 1'b0, 32'h0000AAAA, 32'h00000069, 32'h0, 0, 1);
        issue(1'b0, 2'd0, 1'b1, 32'h0000AAAA, 32'h0, 32'h00690000, 0, 1);
        issue(1'b0, 2'd0, 1'b1, 32'h0000AAAA, 32'h0, 32'h00800000, 0, 1);
        issue(1'b0, 2'd0, 1'b0, 32'h0000AAAA, 32'h0, 32'h00800000, 1, 1);
        issue(1'b0, 2'd1, 1'b1, 32'h0000AAAA, 32'h0, 32'h80010000, 0, 1);
        issue(1'b0, 2'd1, 1'b0, 32'h0000AAAA, 32'h0, 32'h80010000, 2, 1);
        issue(1'b0, 2'd2, 1'b0, 32'h00001000, 32'h0, 32'hCAFE1234, 3, 1);
        issue(1'b0, 2'd2, 1'b0, 32'h00001002, 32'h0, 32'h0, 0, 1);
        issue(1'b1, 2'd1, 1'b0, 32'h0000AAAB, 32'h1234, 32'h0, 0, 1);
        issue(1'b0, 2'd3, 1'b0, 32'h00000000, 32'h0, 32'h0, 0, 1);
        issue(1'b0, 2'd2, 1'b0, 32'h00004000, 32'h0, 32'h11111111, 20, 1);
        issue(1'b1, 2'd1, 1'b0, 32'h00004002, 32'hBEEF, 32'h0, TMO - 1, 1);

        // Reset in the middle of a stalled bus phase.
        issue(1'b0, 2'd2, 1'b0, 32'h00002000, 32'h0, 32'h12345678, 100, 0);
        guard = 0;
        while (!read && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!read) fail_now("mid_reset_read_start");
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid_reset_read_drop", {31'd0, read}, 32'd0);
        chk("mid_reset_write", {31'd0, write}, 32'd0);
        chk("mid_reset_no_resp", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("mid_reset_no_resp_hold", {31'd0, resp_valid}, 32'd0);
        #2 reset = 1'b1;
        issue(1'b1, 2'd2, 1'b0, 32'h00003004, 32'hDEADBEEF, 32'h0, 1, 1);

        // Randomized traffic.
        for (int n = 0; n < 150; n++) begin
            wr = 1'($urandom);
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = $urandom;
            if ($urandom_range(0, 4) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
            w  = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO, TMO + 3) : $urandom_range(0, 4);
            issue(wr, sz, 1'($urandom), a, $urandom, $urandom, w, 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        guard = 0;
        while ((resp_q.size() != 0 || busy) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (resp_q.size() != 0) fail_now("resp_drain");
        chk("bus_q_empty", bus_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
